// File: rtl/vita49_pkg.sv
// vita49_pkg: shared types and constants for the VITA-49 trigger/timestamp capture block.
//   cap_rec_t   - one captured packet record {tsi, tsf, beats}
//   Ctrl*Bit    - bit positions inside the ctrl word
//   Stat*       - bit positions / fields inside the status word
//   cap_state_e - capture state machine encoding
package vita49_pkg;

  typedef struct packed {
    logic [31:0] tsi;
    logic [63:0] tsf;
    logic [15:0] beats;
  } cap_rec_t;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlClearBit = 1;
  localparam int unsigned CtrlPopBit   = 2;

  localparam int unsigned StatBusyBit  = 0;
  localparam int unsigned StatEmptyBit = 1;
  localparam int unsigned StatFullBit  = 2;
  localparam int unsigned StatOvfBit   = 3;
  localparam int unsigned StatLevelLsb = 4;
  localparam int unsigned StatLevelMsb = 10;
  localparam int unsigned StatDropLsb  = 24;
  localparam int unsigned StatDropMsb  = 31;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StActive = 2'd2
  } cap_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vita49_cap_fifo.sv
// vita49_cap_fifo: first-word-fall-through FIFO of capture records.
//   clk, rst      - clock, asynchronous active-high reset
//   clear         - synchronous flush
//   push, din     - write request and record; ignored when full unless popping the same cycle
//   pop           - read request; ignored when empty
//   dout          - head record, all-zero while empty
//   full, empty   - occupancy flags
//   level         - number of stored records
module vita49_cap_fifo
  import vita49_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  cap_rec_t   din,
  input  logic       pop,
  output cap_rec_t   dout,
  output logic       full,
  output logic       empty,
  output logic [6:0] level
);

  localparam int unsigned AW     = $clog2(Depth);
  localparam logic [6:0]  DepthL = 7'(Depth);

  cap_rec_t        mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [6:0]      cnt_q;
  logic            do_push, do_pop;

  assign empty   = (cnt_q == 7'd0);
  assign full    = (cnt_q == DepthL);
  assign level   = cnt_q;
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 7'd1;
        2'b01:   cnt_q <= cnt_q - 7'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vita49_trig_capture.sv
// vita49_trig_capture: passes an AXI-Stream through untouched and records, for every packet,
// the timing-unit time (tsi/tsf) at its first beat and its beat count into a record FIFO.
//   AXIS_ACLK, AXIS_ARESET     - clock, asynchronous active-high reset
//   S_AXIS_* / M_AXIS_*        - sample stream in / combinational pass-through out
//   ctrl                       - [0] en, [1] clear, [2] pop (rising edge)
//   status                     - [0] busy, [1] empty, [2] full, [3] ovf, [10:4] level, [31:24] drops
//   tsi, tsf                   - current time
//   rd_tsi, rd_tsf, rd_beats   - head record (zero while empty)
// Build option: define VITA49_CAP_DROP_CNT_EN for the saturating drop counter on status[31:24].
module vita49_trig_capture
  import vita49_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_NUM_BYTES = 4,
  parameter int unsigned C_FIFO_DEPTH           = 8
) (
  input  logic                                AXIS_ACLK,
  input  logic                                AXIS_ARESET,
  input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  input  logic [31:0]                         ctrl,
  output logic [31:0]                         status,
  input  logic [31:0]                         tsi,
  input  logic [63:0]                         tsf,
  output logic [31:0]                         rd_tsi,
  output logic [63:0]                         rd_tsf,
  output logic [15:0]                         rd_beats
);

  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign M_AXIS_TVALID = S_AXIS_TVALID;
  assign S_AXIS_TREADY = M_AXIS_TREADY;

  logic        beat;
  logic [2:0]  ctrl_q;
  logic        pop_prev_q;
  logic [31:0] tsi_q, cap_tsi_q, cap_tsi_d;
  logic [63:0] tsf_q, cap_tsf_q, cap_tsf_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  cap_state_e  state_q, state_d;
  logic        en, clear, pop_pulse;
  logic        push, overflow;
  cap_rec_t    push_rec, head;
  logic        fifo_full, fifo_empty;
  logic [6:0]  fifo_level;
  logic        ovf_q;
  logic [7:0]  drop_cnt;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl[31:3];
  assign beat        = S_AXIS_TVALID & M_AXIS_TREADY;
  assign en          = ctrl_q[CtrlEnBit];
  assign clear       = ctrl_q[CtrlClearBit];
  assign pop_pulse   = ctrl_q[CtrlPopBit] & ~pop_prev_q;
  assign cnt_inc     = sat_inc16(cnt_q);

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      ctrl_q     <= '0;
      pop_prev_q <= 1'b0;
      tsi_q      <= '0;
      tsf_q      <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      cap_tsi_q  <= '0;
      cap_tsf_q  <= '0;
    end else begin
      ctrl_q     <= ctrl[2:0];
      pop_prev_q <= ctrl_q[CtrlPopBit];
      tsi_q      <= tsi;
      tsf_q      <= tsf;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_tsi_q  <= cap_tsi_d;
      cap_tsf_q  <= cap_tsf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_tsi_d = cap_tsi_q;
    cap_tsf_d = cap_tsf_q;
    push      = 1'b0;
    push_rec  = '0;
    if (clear || !en) begin
      // Leaving ACTIVE this way drops the partial packet.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (beat) begin
            if (S_AXIS_TLAST) begin
              push     = 1'b1;
              push_rec = '{tsi: tsi_q, tsf: tsf_q, beats: 16'd1};
            end else begin
              cap_tsi_d = tsi_q;
              cap_tsf_d = tsf_q;
              cnt_d     = 16'd1;
              state_d   = StActive;
            end
          end
        end
        StActive: begin
          if (beat) begin
            if (S_AXIS_TLAST) begin
              push     = 1'b1;
              push_rec = '{tsi: cap_tsi_q, tsf: cap_tsf_q, beats: cnt_inc};
              cnt_d    = '0;
              state_d  = StArmed;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  vita49_cap_fifo #(
    .Depth (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (AXIS_ACLK),
    .rst   (AXIS_ARESET),
    .clear (clear),
    .push  (push),
    .din   (push_rec),
    .pop   (pop_pulse),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A pop in the same cycle makes room, so that case is not an overflow.
  assign overflow = push & fifo_full & ~pop_pulse;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET)   ovf_q <= 1'b0;
    else if (clear)    ovf_q <= 1'b0;
    else if (overflow) ovf_q <= 1'b1;
  end

`ifdef VITA49_CAP_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET)                             drop_cnt_q <= '0;
    else if (clear)                              drop_cnt_q <= '0;
    else if (overflow && drop_cnt_q != 8'hFF)    drop_cnt_q <= drop_cnt_q + 8'd1;
  end
  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

  always_comb begin
    status                            = '0;
    status[StatBusyBit]               = (state_q != StIdle);
    status[StatEmptyBit]              = fifo_empty;
    status[StatFullBit]               = fifo_full;
    status[StatOvfBit]                = ovf_q;
    status[StatLevelMsb:StatLevelLsb] = fifo_level;
    status[StatDropMsb:StatDropLsb]   = drop_cnt;
  end

  assign rd_tsi   = head.tsi;
  assign rd_tsf   = head.tsf;
  assign rd_beats = head.beats;

endmodule

// File: tb/tb_vita49_trig_capture.sv
// tb_vita49_trig_capture: directed, table-driven bench for vita49_trig_capture.
module tb_vita49_trig_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata, m_tdata;
  logic [3:0]  s_tstrb, m_tstrb;
  logic        s_tlast, s_tvalid, s_tready;
  logic        m_tlast, m_tvalid, m_tready;
  logic [31:0] ctrl, status, tsi, rd_tsi;
  logic [63:0] tsf, rd_tsf;
  logic [15:0] rd_beats;

  int checks   = 0;
  int failures = 0;

`ifdef VITA49_CAP_DROP_CNT_EN
  localparam logic [7:0] DropExp = 8'd2;
`else
  localparam logic [7:0] DropExp = 8'd0;
`endif

  always #5 clk = ~clk;

  vita49_trig_capture #(
    .C_AXIS_TDATA_NUM_BYTES (4),
    .C_FIFO_DEPTH           (8)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .ctrl          (ctrl),
    .status        (status),
    .tsi           (tsi),
    .tsf           (tsf),
    .rd_tsi        (rd_tsi),
    .rd_tsf        (rd_tsf),
    .rd_beats      (rd_beats)
  );

  // Pass-through must hold on every cycle, including during reset.
  always @(negedge clk) begin
    checks++;
    if ({m_tdata, m_tstrb, m_tlast, m_tvalid, s_tready} !==
        {s_tdata, s_tstrb, s_tlast, s_tvalid, m_tready}) begin
      failures++;
      $display("FAIL passthrough: actual=0x%0h required=0x%0h",
               {m_tdata, m_tstrb, m_tlast, m_tvalid, s_tready},
               {s_tdata, s_tstrb, s_tlast, s_tvalid, m_tready});
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic last);
    s_tvalid = 1'b1;
    s_tlast  = last;
    s_tdata  = $urandom;
    s_tstrb  = 4'hF;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pop_one();
    ctrl[2] = 1'b1;
    step();
    ctrl[2] = 1'b0;
    step();
  endtask

  typedef struct {
    logic [31:0] tsi;
    logic [63:0] tsf;
    int          nbeats;
    bit          stall;
    logic [31:0] exp_tsi;
    logic [63:0] exp_tsf;
    logic [15:0] exp_beats;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'd5, 64'd100, 4, 1'b0, 32'd5, 64'd100, 16'd4};
    vecs[1] = '{32'd7, 64'h1_0000_0000, 1, 1'b0, 32'd7, 64'h1_0000_0000, 16'd1};
    vecs[2] = '{32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFF0, 3, 1'b1,
                32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFF0, 16'd3};
    vecs[3] = '{32'd0, 64'd0, 2, 1'b0, 32'd0, 64'd0, 16'd2};

    rst = 1'b1;
    s_tdata = '0; s_tstrb = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b1;
    ctrl = '0; tsi = '0; tsf = '0;
    repeat (3) step();
    chk("reset_status", status, 32'h2);
    chk("reset_rd", {rd_tsi, rd_tsf, rd_beats}, '0);
    rst = 1'b0;
    step();
    chk("post_reset_status", status, 32'h2);

    ctrl = 32'h1;
    step(); step();
    chk("armed_status", status, 32'h3);

    // Table: one packet per entry into an empty FIFO, then read back and pop.
    for (int i = 0; i < 4; i++) begin
      tsi = vecs[i].tsi;
      tsf = vecs[i].tsf;
      step();
      for (int b = 0; b < vecs[i].nbeats; b++) begin
        if (vecs[i].stall && b == 1) begin
          // Valid without ready is not a beat.
          s_tvalid = 1'b1; m_tready = 1'b0;
          step();
          s_tvalid = 1'b0; m_tready = 1'b1;
        end
        beat(b == vecs[i].nbeats - 1);
        if (b == 0) begin
          tsi = ~vecs[i].tsi;
          tsf = ~vecs[i].tsf;
        end
      end
      chk($sformatf("vec%0d_rd_tsi", i), rd_tsi, vecs[i].exp_tsi);
      chk($sformatf("vec%0d_rd_tsf", i), rd_tsf, vecs[i].exp_tsf);
      chk($sformatf("vec%0d_rd_beats", i), rd_beats, vecs[i].exp_beats);
      chk($sformatf("vec%0d_level", i), status[10:4], 7'd1);
      chk($sformatf("vec%0d_flags", i), status[3:0], 4'b0001);
      pop_one();
      chk($sformatf("vec%0d_popped", i), {status[10:0], rd_beats}, {7'd0, 4'b0011, 16'd0});
    end

    // Overflow: ten single-beat packets into depth 8, no pops.
    for (int k = 0; k < 10; k++) begin
      tsi = k;
      tsf = 64'(k * 10);
      step();
      beat(1'b1);
    end
    chk("ovf_full", status[2], 1'b1);
    chk("ovf_sticky", status[3], 1'b1);
    chk("ovf_level", status[10:4], 7'd8);
    chk("ovf_drops", status[31:24], DropExp);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_head%0d", k), rd_tsi, 32'(k));
      pop_one();
    end
    chk("drain_empty", status[2:1], 2'b01);
    chk("drain_level", status[10:4], 7'd0);
    chk("drain_rd_zero", {rd_tsi, rd_tsf, rd_beats}, '0);
    chk("drain_ovf_kept", status[3], 1'b1);

    // Clear flushes flags and forces IDLE.
    ctrl = 32'h3;
    step(); step();
    chk("clear_status", status, 32'h2);
    ctrl = 32'h1;
    step(); step();

    // Simultaneous pop and push while full.
    for (int k = 0; k < 8; k++) begin
      tsi = k;
      step();
      beat(1'b1);
    end
    chk("simul_full_before", status[2], 1'b1);
    tsi = 32'd8;
    ctrl = 32'h5;
    step();
    ctrl = 32'h1;
    beat(1'b1);
    chk("simul_level", status[10:4], 7'd8);
    chk("simul_full", status[2], 1'b1);
    chk("simul_ovf", status[3], 1'b0);
    chk("simul_head", rd_tsi, 32'd1);
    repeat (7) pop_one();
    chk("simul_tail", rd_tsi, 32'd8);
    pop_one();
    pop_one();
    chk("pop_empty_ignored", status[10:1], {7'd0, 3'b001});

    // en dropped mid-packet, then re-armed for a clean 2-beat packet.
    tsi = 32'd50;
    step();
    beat(1'b0); beat(1'b0); beat(1'b0);
    ctrl = 32'h0;
    step(); step();
    chk("disarm_status", status, 32'h2);
    ctrl = 32'h1;
    tsi = 32'd77;
    tsf = 64'd777;
    step(); step();
    beat(1'b0);
    beat(1'b1);
    chk("rearm_level", status[10:4], 7'd1);
    chk("rearm_beats", rd_beats, 16'd2);
    chk("rearm_tsi", rd_tsi, 32'd77);
    chk("rearm_tsf", rd_tsf, 64'd777);
    pop_one();

    // Reset mid-packet.
    tsi = 32'd9;
    step();
    beat(1'b0); beat(1'b0);
    rst = 1'b1;
    beat(1'b0); beat(1'b0);
    m_tready = 1'b0; s_tvalid = 1'b1;
    step();
    chk("rst_tready", s_tready, 1'b0);
    m_tready = 1'b1; s_tvalid = 1'b0;
    chk("rst_status", status, 32'h2);
    chk("rst_rd", {rd_tsi, rd_beats}, '0);
    rst = 1'b0;
    beat(1'b1);
    chk("rst_no_record", status, 32'h2);
    step();
    chk("rst_rearmed", status, 32'h3);
    beat(1'b1);
    chk("rst_recover", {rd_tsi, rd_beats}, {32'd9, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
